seg7_scan_decoder: RTL and testbench

//   Receive-side counterpart of the multiplexed 7-segment display interface.

---
 rtl/seg7_scan_decoder.sv | 177 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//   Receive side of a multiplexed 7-segment display bus. Watches the scanned
//   anode/cathode lines, waits for each digit's drive to settle, decodes the
//   glyph back to a hex nibble plus decimal point, and publishes a whole frame
//   once every digit position has been captured.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   seg_an       in   [NUM_DIGITS-1:0] anodes, active-low, one-hot-low per digit
//   seg_cat      in   [7:0] cathodes, active-low; [6:0]=g..a, [7]=dp
//   value        out  [4*NUM_DIGITS-1:0] decoded nibbles, digit i at [4i+3:4i]
//   dp           out  [NUM_DIGITS-1:0] decoded decimal points, 1 = lit
//   digit_err    out  [NUM_DIGITS-1:0] 1 = last captured pattern was not a hex glyph
//   frame_valid  out  one-cycle pulse when value/dp/digit_err update
//   stale        out  no capture seen within TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int NUM_DIGITS     = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   seg_an,
    input  logic [7:0]              seg_cat,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    stale
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ZW = $clog2(NUM_DIGITS + 1);

    // {err, nibble}; unknown patterns decode to nibble 0 with err set
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F: r = 5'h00;
            7'h06: r = 5'h01;
            7'h5B: r = 5'h02;
            7'h4F: r = 5'h03;
            7'h66: r = 5'h04;
            7'h6D: r = 5'h05;
            7'h7D: r = 5'h06;
            7'h07: r = 5'h07;
            7'h7F: r = 5'h08;
            7'h6F: r = 5'h09;
            7'h77: r = 5'h0A;
            7'h7C: r = 5'h0B;
            7'h39: r = 5'h0C;
            7'h5E: r = 5'h0D;
            7'h79: r = 5'h0E;
            7'h71: r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    logic [NUM_DIGITS-1:0]   r_an_q, r_an_prev;
    logic [7:0]              r_cat_q, r_cat_prev;
    logic [SW-1:0]           r_settle;
    logic [4*NUM_DIGITS-1:0] r_sh_val;
    logic [NUM_DIGITS-1:0]   r_sh_dp, r_sh_err, r_seen;
    logic [TW-1:0]           r_to_cnt;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_dp, r_err;
    logic                    r_fv, r_stale;

    logic [ZW-1:0]           w_zero_cnt;
    logic                    w_digit_ok, w_stable, w_capture, w_frame;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [SW-1:0]           w_settle_nxt;
    logic [TW-1:0]           w_to_nxt;
    logic [4:0]              w_dec;

    // A digit is addressed only when exactly one anode is pulled low
    always_comb begin
        w_zero_cnt = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_an_q[i]) w_zero_cnt = w_zero_cnt + ZW'(1);
        end
    end

    assign w_digit_ok = (w_zero_cnt == ZW'(1));
    assign w_sel      = ~r_an_q;
    assign w_stable   = (r_an_q == r_an_prev) && (r_cat_q == r_cat_prev);
    assign w_dec      = f_decode(~r_cat_q[6:0]);
    assign w_frame    = &r_seen;

    always_comb begin
        if (!w_digit_ok)
            w_settle_nxt = '0;
        else if (!w_stable)
            w_settle_nxt = SW'(1);
        else if (r_settle != SW'(SETTLE_CYCLES))
            w_settle_nxt = r_settle + SW'(1);
        else
            w_settle_nxt = r_settle;
    end

    // Fire once per dwell: only on the transition into the settled count,
    // not while sitting saturated on an unchanged pattern
    assign w_capture = w_digit_ok && (w_settle_nxt == SW'(SETTLE_CYCLES)) &&
                       !(w_stable && (r_settle == SW'(SETTLE_CYCLES)));

    always_comb begin
        if (w_capture)
            w_to_nxt = '0;
        else if (r_to_cnt != TW'(TIMEOUT_CYCLES))
            w_to_nxt = r_to_cnt + TW'(1);
        else
            w_to_nxt = r_to_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an_q     <= '0;
            r_an_prev  <= '0;
            r_cat_q    <= '0;
            r_cat_prev <= '0;
            r_settle   <= '0;
            r_sh_val   <= '0;
            r_sh_dp    <= '0;
            r_sh_err   <= '0;
            r_seen     <= '0;
            r_to_cnt   <= '0;
            r_value    <= '0;
            r_dp       <= '0;
            r_err      <= '0;
            r_fv       <= 1'b0;
            r_stale    <= 1'b1;
        end else begin
            r_an_q     <= seg_an;
            r_cat_q    <= seg_cat;
            r_an_prev  <= r_an_q;
            r_cat_prev <= r_cat_q;
            r_settle   <= w_settle_nxt;
            r_to_cnt   <= w_to_nxt;

            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_capture && w_sel[i]) begin
                    r_sh_val[4*i +: 4] <= w_dec[3:0];
                    r_sh_dp[i]         <= ~r_cat_q[7];
                    r_sh_err[i]        <= w_dec[4];
                end
            end

            // A capture landing on the publish cycle starts the next frame
            r_seen <= (w_frame ? '0 : r_seen) | (w_capture ? w_sel : '0);

            r_fv <= w_frame;
            if (w_frame) begin
                r_value <= r_sh_val;
                r_dp    <= r_sh_dp;
                r_err   <= r_sh_err;
            end

            // Publishing a frame takes priority over a coincident timeout
            if (w_frame)
                r_stale <= 1'b0;
            else if (w_to_nxt == TW'(TIMEOUT_CYCLES))
                r_stale <= 1'b1;
        end
    end

    assign value       = r_value;
    assign dp          = r_dp;
    assign digit_err   = r_err;
    assign frame_valid = r_fv;
    assign stale       = r_stale;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

  localparam int NUM = 4;
  localparam int S   = 4;
  localparam int TO  = 64;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frame_t;

  logic        clk, rst;
  logic [3:0]  seg_an;
  logic [7:0]  seg_cat;
  logic [15:0] value;
  logic [3:0]  dp, digit_err;
  logic        frame_valid, stale;

  seg7_scan_decoder #(.NUM_DIGITS(NUM), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .seg_an(seg_an), .seg_cat(seg_cat),
    .value(value), .dp(dp), .digit_err(digit_err),
    .frame_valid(frame_valid), .stale(stale)
  );

  logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int checks = 0;
  int errors = 0;
  int n_frames = 0;

  logic [15:0] m_val;
  logic [3:0]  m_dp, m_err, m_seen;
  frame_t      exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      frame_t e;
      n_frames++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected frame_valid at %0t value=%h", $time, value);
      end else begin
        e = exp_q.pop_front();
        if ({value, dp, digit_err} !== {e.val, e.dp, e.err}) begin
          errors++;
          $display("FAIL frame mismatch at %0t got %h/%b/%b exp %h/%b/%b",
                   $time, value, dp, digit_err, e.val, e.dp, e.err);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input bit cond, input string msg);
    checks++;
    if (!cond) begin
      errors++;
      $display("FAIL %s at %0t", msg, $time);
    end
  endtask

  function automatic void model_reset();
    m_val = '0; m_dp = '0; m_err = '0; m_seen = '0;
    exp_q.delete();
  endfunction

  task automatic dwell(input int idx, input logic [6:0] seg, input logic dpb, input int n);
    logic [3:0] nib;
    logic er;
    seg_an  = ~(4'b0001 << idx);
    seg_cat = {~dpb, ~seg};
    if (n >= S) begin
      nib = 4'h0; er = 1'b1;
      for (int g = 0; g < 16; g++)
        if (GLYPH[g] == seg) begin nib = g[3:0]; er = 1'b0; end
      m_val[4*idx +: 4] = nib;
      m_dp[idx]   = dpb;
      m_err[idx]  = er;
      m_seen[idx] = 1'b1;
      if (&m_seen) begin
        exp_q.push_back({m_val, m_dp, m_err});
        m_seen = '0;
      end
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic blank(input logic [3:0] an, input int n);
    seg_an  = an;
    seg_cat = 8'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan_random(input bit with_blank);
    for (int idx = 3; idx >= 0; idx--) begin
      dwell(idx, GLYPH[$urandom_range(0, 15)], 1'($urandom_range(0, 1)), $urandom_range(S, S + 4));
      if (with_blank) begin
        blank(4'b1111, $urandom_range(1, 3));
        blank(4'b1001, $urandom_range(1, 3));
      end
    end
  endtask

  task automatic scan_1a3f();
    dwell(3, GLYPH[1],  1'b0, 8);
    dwell(2, GLYPH[10], 1'b0, 8);
    dwell(1, GLYPH[3],  1'b0, 8);
    dwell(0, GLYPH[15], 1'b0, 8);
  endtask

  task automatic wait_frames(input int target, input string msg);
    int k;
    k = 0;
    while (n_frames < target && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (n_frames < target) begin
      errors++;
      $display("FAIL wait expired: %s (frames %0d, want %0d)", msg, n_frames, target);
    end
  endtask

  task automatic check_reset(input string msg);
    check({value, dp, digit_err, frame_valid, stale} === {16'h0, 4'h0, 4'h0, 1'b0, 1'b1}, msg);
  endtask

  initial begin
    int base;
    int cnt;
    logic [15:0] held;

    rst = 1'b1; seg_an = 4'hF; seg_cat = 8'hFF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("power-on reset values");
    rst = 1'b0;
    @(posedge clk);
    #1;

    base = n_frames;
    scan_1a3f();
    wait_frames(base + 1, "clean scan 1A3F");
    check(value === 16'h1A3F && dp === 4'h0 && digit_err === 4'h0, "1A3F outputs");
    check(stale === 1'b0, "stale cleared by frame");
    scan_1a3f();
    scan_1a3f();
    wait_frames(base + 3, "repeated scans");
    repeat (4) @(posedge clk);
    #1;
    check(n_frames == base + 3, "one pulse per scan");

    dwell(3, GLYPH[2], 1'b0, 8);
    seg_an  = 4'b1011;
    seg_cat = {1'b1, ~GLYPH[6]};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset("mid-dwell async reset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = n_frames;
    dwell(3, GLYPH[4], 1'b0, 8);
    dwell(2, GLYPH[5], 1'b0, 8);
    dwell(1, GLYPH[6], 1'b0, 8);
    check(n_frames == base, "no frame before full new scan");
    dwell(0, GLYPH[7], 1'b0, 8);
    wait_frames(base + 1, "frame after reset rescan");
    check(value === 16'h4567, "value after reset rescan");

    base = n_frames;
    dwell(3, GLYPH[8], 1'b0, 8);
    dwell(2, GLYPH[9], 1'b0, 8);
    dwell(1, GLYPH[11], 1'b0, 8);
    seg_an = 4'b1110;
    for (int t = 0; t < 10; t++) begin
      seg_cat = {1'b1, ~GLYPH[(t % 2) ? 12 : 13]};
      repeat (2) @(posedge clk);
      #1;
    end
    check(n_frames == base, "glitch: no frame");
    check(dut.r_seen[0] === 1'b0, "glitch: seen[0] stays 0");
    dwell(0, GLYPH[12], 1'b0, 8);
    wait_frames(base + 1, "frame after glitch");

    base = n_frames;
    dwell(3, GLYPH[5], 1'b0, 8);
    dwell(2, 7'h49,    1'b0, 8);
    dwell(1, GLYPH[7], 1'b1, 8);
    dwell(0, GLYPH[9], 1'b0, 8);
    wait_frames(base + 1, "illegal glyph frame");
    check(digit_err === 4'b0100 && value[11:8] === 4'h0 && dp === 4'b0010, "illegal glyph decode");

    base = n_frames;
    for (int r = 0; r < 3; r++) scan_random(1'b1);
    wait_frames(base + 3, "blanking scans");

    base = n_frames;
    scan_1a3f();
    wait_frames(base + 1, "pre-timeout frame");
    held = value;
    seg_an = 4'hF;
    cnt = 0;
    while (stale !== 1'b1 && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check(stale === 1'b1, "stale asserted after timeout");
    check(cnt == TO - (8 - S - 1), "stale timing");
    check(value === held, "value held while stale");
    base = n_frames;
    scan_1a3f();
    wait_frames(base + 1, "resume after stale");
    check(stale === 1'b0, "stale cleared on resume");

    repeat (10) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "all expected frames observed");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
